// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - button synchroniser, debouncer and move/start pulse generator
//
// Purpose: turns the raw active-low left/right/start push-buttons into
// one-frame command pulses for the game core. Each button is synchronised
// with two flops and then debounced. Left and right each drive a move FSM
// (IDLE/DELAY/REPEAT) that gives delayed auto-repeat. Start gives a single
// pulse per press.
//
// Ports:
//   clock        in   framerate clock, rising edge
//   resetn       in   asynchronous active-low reset
//   btn_left_n   in   raw left button, active-low, asynchronous
//   btn_right_n  in   raw right button, active-low, asynchronous
//   btn_start_n  in   raw start button, active-low, asynchronous
//   key_left     out  one-cycle move-left pulse, registered
//   key_right    out  one-cycle move-right pulse, registered
//   start_game   out  one-cycle start pulse, registered

module key_conditioner #(
  parameter int DEBOUNCE      = 2,
  parameter int DAS_DELAY     = 10,
  parameter int REPEAT_PERIOD = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn_left_n,
  input  logic btn_right_n,
  input  logic btn_start_n,
  output logic key_left,
  output logic key_right,
  output logic start_game
);

  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);
  localparam logic [4:0] DAS_MAX = 5'(DAS_DELAY);
  localparam logic [4:0] REP_MAX = 5'(REPEAT_PERIOD);

  // Button index: 0 = left, 1 = right, 2 = start.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic [2:0]      pressed;
  logic [2:0]      s1_q;
  logic [2:0]      s2_q;
  logic [2:0]      db_q;
  logic [2:0]      db_d;
  logic [2:0][3:0] dcnt_q;
  logic [2:0][3:0] dcnt_d;

  logic            db_start_q;
  logic            start_q;
  logic            start_d;

  logic [1:0]      eff;
  state_e          state_q [2];
  state_e          state_d [2];
  logic [1:0][4:0] rcnt_q;
  logic [1:0][4:0] rcnt_d;
  logic [1:0]      pulse_q;
  logic [1:0]      pulse_d;

  // Invert so that 1 means pressed from the synchroniser onwards.
  assign pressed = ~{btn_start_n, btn_right_n, btn_left_n};

  // Debounce: db follows s2 only after s2 has disagreed with it for
  // DEBOUNCE consecutive edges; any agreeing edge restarts the count.
  always_comb begin
    db_d   = db_q;
    dcnt_d = dcnt_q;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] == db_q[i]) begin
        dcnt_d[i] = 4'd0;
      end else if (dcnt_q[i] + 4'd1 == DEB_MAX) begin
        db_d[i]   = s2_q[i];
        dcnt_d[i] = 4'd0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + 4'd1;
      end
    end
  end

  assign start_d = db_q[2] & ~db_start_q;

  // Holding both directions cancels both, so neither FSM advances.
  assign eff[0] = db_q[0] & ~db_q[1];
  assign eff[1] = db_q[1] & ~db_q[0];

  // Move FSM next state and repeat counter.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (!eff[i]) begin
        state_d[i] = IDLE;
        rcnt_d[i]  = 5'd0;
      end else begin
        case (state_q[i])
          IDLE: begin
            state_d[i] = DELAY;
            rcnt_d[i]  = 5'd1;
          end
          DELAY: begin
            if (rcnt_q[i] == DAS_MAX) begin
              state_d[i] = REPEAT;
              rcnt_d[i]  = 5'd1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 5'd1;
            end
          end
          REPEAT: begin
            if (rcnt_q[i] == REP_MAX) begin
              rcnt_d[i] = 5'd1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 5'd1;
            end
          end
          default: begin
            state_d[i] = IDLE;
            rcnt_d[i]  = 5'd0;
          end
        endcase
      end
    end
  end

  // Move FSM pulse decode, registered below so every pulse is one cycle.
  always_comb begin
    pulse_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (eff[i]) begin
        case (state_q[i])
          IDLE:    pulse_d[i] = 1'b1;
          DELAY:   pulse_d[i] = (rcnt_q[i] == DAS_MAX);
          REPEAT:  pulse_d[i] = (rcnt_q[i] == REP_MAX);
          default: pulse_d[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q       <= 3'b000;
      s2_q       <= 3'b000;
      db_q       <= 3'b000;
      dcnt_q     <= '0;
      db_start_q <= 1'b0;
      start_q    <= 1'b0;
      rcnt_q     <= '0;
      pulse_q    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
      end
    end else begin
      s1_q       <= pressed;
      s2_q       <= s1_q;
      db_q       <= db_d;
      dcnt_q     <= dcnt_d;
      db_start_q <= db_q[2];
      start_q    <= start_d;
      rcnt_q     <= rcnt_d;
      pulse_q    <= pulse_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign key_left   = pulse_q[0];
  assign key_right  = pulse_q[1];
  assign start_game = start_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - self-checking bench for key_conditioner

module tb_key_conditioner;

  localparam int DEB = 2;
  localparam int DAS = 10;
  localparam int REP = 3;
  localparam int LAT = DEB + 2;  // edges from first raw sample to first pulse

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic btn_left_n = 1'b1;
  logic btn_right_n = 1'b1;
  logic btn_start_n = 1'b1;
  logic key_left;
  logic key_right;
  logic start_game;

  always #5 clock = ~clock;

  key_conditioner #(
    .DEBOUNCE      (DEB),
    .DAS_DELAY     (DAS),
    .REPEAT_PERIOD (REP)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .btn_left_n  (btn_left_n),
    .btn_right_n (btn_right_n),
    .btn_start_n (btn_start_n),
    .key_left    (key_left),
    .key_right   (key_right),
    .start_game  (start_game)
  );

  // want = {key_left, key_right, start_game} after the edge that samples the inputs
  typedef struct {
    logic       l_n;
    logic       r_n;
    logic       s_n;
    logic [2:0] want;
  } vec_t;

  vec_t       stim_q[$];
  logic [2:0] exp_q[$];
  vec_t       bounce_tbl[10];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got {left,right,start}=%b, expected %b", name, act, req);
    end
  endtask

  task automatic push(input logic l_n, input logic r_n, input logic s_n, input logic [2:0] want);
    vec_t v;
    v.l_n  = l_n;
    v.r_n  = r_n;
    v.s_n  = s_n;
    v.want = want;
    stim_q.push_back(v);
  endtask

  // Drive each queued vector, record its expectation, compare after the edge.
  task automatic run(input string name);
    vec_t       v;
    logic [2:0] e;
    int         idx;
    idx = 0;
    while (stim_q.size() > 0) begin
      v = stim_q.pop_front();
      btn_left_n  = v.l_n;
      btn_right_n = v.r_n;
      btn_start_n = v.s_n;
      exp_q.push_back(v.want);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, idx), {key_left, key_right, start_game}, e);
      idx++;
    end
  endtask

  // Move pulse expected after edge j of a press held for n_low raw samples.
  function automatic logic move_exp(input int j, input int n_low);
    int r;
    r = j - LAT;
    if (r < 0 || r >= n_low) return 1'b0;
    return (r == 0) || (r == DAS) || (r > DAS && ((r - DAS) % REP) == 0);
  endfunction

  // Single button (0 left, 1 right, 2 start) low for n_low cycles, then released.
  task automatic gen_hold(input int which, input int n_low, input int n_after);
    for (int j = 0; j < n_low + n_after; j++) begin
      logic       lo;
      logic [2:0] e;
      lo = (j < n_low);
      e  = 3'b000;
      case (which)
        0:       e[2] = move_exp(j, n_low);
        1:       e[1] = move_exp(j, n_low);
        default: e[0] = (j == LAT);
      endcase
      push((which == 0) ? ~lo : 1'b1, (which == 1) ? ~lo : 1'b1,
           (which == 2) ? ~lo : 1'b1, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] bounce_pat;

    // Left low 1, high 1, low 1, then high: shorter than the debounce window.
    bounce_pat = 10'b11_1111_1010;
    for (int i = 0; i < 10; i++) begin
      bounce_tbl[i] = '{l_n: bounce_pat[i], r_n: 1'b1, s_n: 1'b1, want: 3'b000};
    end

    // Reset held with every button pressed: outputs stay low.
    btn_left_n  = 1'b0;
    btn_right_n = 1'b0;
    btn_start_n = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      check("reset_hold", {key_left, key_right, start_game}, 3'b000);
    end
    resetn = 1'b1;

    // All pressed out of reset: start pulses after edge 4, left+right cancel.
    for (int j = 0; j < 12; j++) push(1'b0, 1'b0, 1'b0, (j == LAT) ? 3'b001 : 3'b000);
    for (int j = 0; j < 8; j++) push(1'b1, 1'b1, 1'b1, 3'b000);
    run("reset_release");

    for (int i = 0; i < 10; i++) stim_q.push_back(bounce_tbl[i]);
    run("bounce");

    gen_hold(1, 30, 8);
    run("auto_repeat");

    gen_hold(2, 40, 8);
    run("start_first");
    gen_hold(2, 10, 8);
    run("start_second");

    // Left alone, then both, then left released: right takes over fresh.
    for (int j = 0; j < 41; j++) begin
      logic [2:0] e;
      e = 3'b000;
      e[2] = (j == 4);
      e[1] = (j == 20) || (j == 30) || (j == 33);
      push((j < 16) ? 1'b0 : 1'b1, (j >= 5 && j < 32) ? 1'b0 : 1'b1, 1'b1, e);
    end
    run("both_held");

    // Reset in the middle of auto-repeat, right on a pulse.
    for (int j = 0; j < 15; j++) push(1'b0, 1'b1, 1'b1, {(j == 4) || (j == 14), 2'b00});
    run("pre_reset");
    #1 resetn = 1'b0;
    #1 check("async_reset", {key_left, key_right, start_game}, 3'b000);
    repeat (2) @(posedge clock);
    #1;
    check("reset_mid", {key_left, key_right, start_game}, 3'b000);
    resetn = 1'b1;
    gen_hold(0, 21, 8);
    run("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Frame-rate input conditioner between the board's raw push-buttons and the game core. It synchronises and debounces the left, right and start buttons, then turns them into one-frame command pulses. Left and right gain delayed auto-repeat; start is a single pulse per press. Runs on the framerate clock, so every output pulse is exactly one game-logic cycle wide and directly drives the core's `key_left`, `key_right` and `start_game` inputs.

## Interface
- `DEBOUNCE`, default 2: consecutive cycles a synchronised level must differ from the debounced state before that state flips. Range 1..15.
- `DAS_DELAY`, default 10: cycles from the first move pulse to the first repeat pulse. Range 1..31.
- `REPEAT_PERIOD`, default 3: cycles between successive repeat pulses. Range 1..31.
- `clock`  in  1  framerate clock (~60 Hz); all flops on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `btn_left_n`  in  1  raw left button, active-low, asynchronous to `clock`.
- `btn_right_n`  in  1  raw right button, active-low, asynchronous.
- `btn_start_n`  in  1  raw start button, active-low, asynchronous.
- `key_left`  out  1  one-cycle move-left pulse, registered.
- `key_right`  out  1  one-cycle move-right pulse, registered.
- `start_game`  out  1  one-cycle start pulse, registered.

## Operation
- **Reset:**
  - All flops clear: synchronisers, debounced states, counters, FSMs (IDLE), outputs 0.
  - 0 means "released" throughout. Each raw input is inverted before its synchroniser.
- **Synchroniser:** two flops per button, `s1 <= ~btn_n`, `s2 <= s1`.
- **Debounce (per button):**
  - Counter `dcnt` (4 bits) increments on each edge where `s2 != db`.
  - It clears to 0 on any edge where `s2 == db`.
  - When it would reach `DEBOUNCE`, `db <= s2` and `dcnt <= 0`.
  - A glitch shorter than `DEBOUNCE` cycles never changes `db`.
- **Start:** `start_game <= db_start & ~db_start_q`, a rising-edge detect. No repeat; a held button gives exactly one pulse.
- **Move FSM (one per direction):** states IDLE, DELAY, REPEAT; 5-bit counter `rcnt`.
  - Effective press: `eff_l = db_left & ~db_right`, `eff_r = db_right & ~db_left`.
  - IDLE, `eff` = 1: pulse 1, `rcnt <= 1`, go to DELAY.
  - DELAY, `eff` = 1: if `rcnt == DAS_DELAY`, pulse 1, `rcnt <= 1`, go to REPEAT. Otherwise `rcnt++`, pulse 0.
  - REPEAT, `eff` = 1: if `rcnt == REPEAT_PERIOD`, pulse 1, `rcnt <= 1`. Otherwise `rcnt++`, pulse 0.
  - Any state, `eff` = 0: go to IDLE, `rcnt <= 0`, pulse 0.
- **Both directions held:** both `eff` are 0, so both FSMs sit in IDLE and no motion occurs.
  - When one button is released, the other becomes a fresh press and pulses on the next edge.
- `key_left` and `key_right` are never 1 in the same cycle.

## Timing
- **Press latency:** raw press first sampled at edge k gives:
  - `s2` = 1 at k+1;
  - `db` = 1 at k+1+`DEBOUNCE`;
  - output pulse high after edge k+2+`DEBOUNCE`, i.e. k+4 with defaults.
- **Release latency:** `db` falls `DEBOUNCE`+1 cycles after the raw release is sampled. The FSM returns to IDLE on the next edge and no pulse is emitted after `db` falls.
- **Repeat cadence:** with the first pulse at edge P, pulses fall at P+`DAS_DELAY`, then every `REPEAT_PERIOD` edges. Defaults give P, P+10, P+13, P+16, …
  - `REPEAT_PERIOD` = 1 gives a pulse every cycle after the delay.
- **Pulse width:** every output pulse is exactly 1 cycle.
  - Back-to-back pulses occur only with `REPEAT_PERIOD` = 1 or `DAS_DELAY` = 1.
- **Reset mid-operation:** asynchronous; outputs drop to 0 immediately.
  - A button still held after `resetn` deasserts is treated as a new press: the full press latency applies, then the first pulse.
- **Counter widths:** counters never exceed their parameter value. Parameters out of range are illegal and not checked.

## Test plan
- **Reset:** hold `resetn`=0 with all buttons pressed → all outputs 0. Release reset at edge 0 → first `key_left`/`key_right`/`start_game` pulse after edge 4. Both left and right pressed → no move pulse.
- **Bounce rejection:** `btn_left_n` low for 1 cycle, high 1, low 1, then high → `key_left` stays 0 throughout. `db_left` never rises with `DEBOUNCE`=2.
- **Auto-repeat:** hold `btn_right_n` low for 30 cycles → `key_right` pulses at P, P+10, P+13, P+16, P+19, P+22, P+25, P+28 (each relative to first pulse P). After release, no further pulse.
- **Start:** hold `btn_start_n` low for 40 cycles → exactly one `start_game` pulse, 4 edges after the first sample. Release and re-press → exactly one more.
- **Both held:**
  - Hold left until the first `key_left` pulse, then add right → no pulses while both are debounced high.
  - Release left → `key_right` pulses the edge after `db_left` falls, then at +10.
- **Reset during repeat:** assert `resetn` mid-REPEAT while left is held → `key_left` goes 0 asynchronously. Deassert → next pulse after the press latency (4 edges), not at the old cadence.
